add_arbiter: RTL and testbench

Round-robin scheduler that shares one WIDTH-bit adder/subtractor among NREQ requesters. Each requester presents operands through a valid/ready handshake. The block grants one requester per cycle, computes the result in the shared datapath and holds it in a single-entry output register with its own valid/ready handshake. It sits between the pin-level input logic of the tt_um top and the shared adder datapath, and replaces the fixed `ui_in + uio_in` connection when several sources need the adder.

---
 rtl/add_arbiter_if.sv | 28 ++
 rtl/add_arbiter.sv | 77 +++++++
 tb/tb_add_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/add_arbiter_if.sv
// add_arbiter_if: requester and response handshake bundle for the shared adder arbiter
interface add_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = $clog2(NREQ)
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       req_op;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WIDTH-1:0]      rsp_sum;
    logic                  rsp_carry;
    logic [IDW-1:0]        rsp_id;
    logic [15:0]           op_count;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_sum, rsp_carry, rsp_id, op_count
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_sum, rsp_carry, rsp_id, op_count
    );
endinterface

// File: rtl/add_arbiter.sv
// add_arbiter: round-robin sharing of one adder/subtractor with a single-entry result register
module add_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    localparam int IDW  = $clog2(NREQ)
) (
    input logic        clk,
    input logic        rst_n,
    add_arbiter_if.slave bus
);
    typedef enum logic {EMPTY, FULL} state_t;

    state_t           state, state_nx;
    logic [IDW-1:0]   rr_ptr, gnt_idx, id_r;
    logic             found, slot_free, xfer;
    logic [WIDTH-1:0] sel_a, sel_b, sum_r;
    logic             sel_op, carry_r;
    logic [WIDTH:0]   res;
    logic [15:0]      cnt_r;

    function automatic int wrap(input int v);
        return v >= NREQ ? v - NREQ : v;
    endfunction

    // first valid requester at or after rr_ptr, wrapping at NREQ
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && bus.req_valid[wrap(int'(rr_ptr) + k)]) begin
                found   = 1'b1;
                gnt_idx = IDW'(wrap(int'(rr_ptr) + k));
            end
        end
    end

    // grant only when the result slot can take a value this edge; operands of the winner feed the adder
    always_comb begin
        slot_free     = state == EMPTY || bus.rsp_ready;
        xfer          = rst_n && slot_free && found;
        bus.req_ready = xfer ? NREQ'(1) << gnt_idx : '0;
        sel_a         = bus.req_a[int'(gnt_idx)*WIDTH +: WIDTH];
        sel_b         = bus.req_b[int'(gnt_idx)*WIDTH +: WIDTH];
        sel_op        = bus.req_op[gnt_idx];
        res           = {1'b0, sel_a} + {1'b0, sel_op ? ~sel_b : sel_b} + {{WIDTH{1'b0}}, sel_op};
        state_nx      = xfer ? FULL : (bus.rsp_ready ? EMPTY : state);
    end

    // output register occupancy
    always_ff @(posedge clk) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nx;
    end

    // result capture, pointer advance and transfer count on each accepted operation
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_r   <= '0;
            carry_r <= 1'b0;
            id_r    <= '0;
            rr_ptr  <= '0;
            cnt_r   <= '0;
        end else if (xfer) begin
            sum_r   <= res[WIDTH-1:0];
            carry_r <= res[WIDTH];
            id_r    <= gnt_idx;
            rr_ptr  <= int'(gnt_idx) == NREQ - 1 ? '0 : gnt_idx + 1'b1;
            cnt_r   <= cnt_r + 16'd1;
        end
    end

    assign bus.rsp_valid = state == FULL;
    assign bus.rsp_sum   = sum_r;
    assign bus.rsp_carry = carry_r;
    assign bus.rsp_id    = id_r;
    assign bus.op_count  = cnt_r;
endmodule

// File: tb/tb_add_arbiter.sv
// tb_add_arbiter: directed checks of arbitration, arithmetic, backpressure, reset and counter wrap
module tb_add_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] rr_sum [4] = '{8'h01, 8'h12, 8'h23, 8'h34};

    add_arbiter_if #(.NREQ(4), .WIDTH(8)) bus ();

    add_arbiter #(.NREQ(4), .WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rsp(input string tag, input logic v, input logic [7:0] s, input logic c,
                           input logic [1:0] id, input logic [15:0] cnt);
        chk({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'(v));
        chk({tag, " rsp_sum"},   32'(bus.rsp_sum),   32'(s));
        chk({tag, " rsp_carry"}, 32'(bus.rsp_carry), 32'(c));
        chk({tag, " rsp_id"},    32'(bus.rsp_id),    32'(id));
        chk({tag, " op_count"},  32'(bus.op_count),  32'(cnt));
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = 4'hF;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        tick();
        tick();
        chk("reset req_ready", 32'(bus.req_ready), 32'h0);
        chk_rsp("reset", 1'b0, 8'h00, 1'b0, 2'd0, 16'd0);

        rst_n             = 1'b1;
        bus.req_valid     = 4'b0100;
        bus.req_a[16 +: 8] = 8'h80;
        bus.req_b[16 +: 8] = 8'h80;
        #1;
        chk("add grant", 32'(bus.req_ready), 32'b0100);
        tick();
        bus.req_valid = 4'b0000;
        chk_rsp("add", 1'b1, 8'h00, 1'b1, 2'd2, 16'd1);

        bus.rsp_ready      = 1'b1;
        bus.req_valid      = 4'b1000;
        bus.req_op[3]      = 1'b1;
        bus.req_a[24 +: 8] = 8'd5;
        bus.req_b[24 +: 8] = 8'd3;
        #1;
        chk("sub grant", 32'(bus.req_ready), 32'b1000);
        tick();
        chk_rsp("sub nb", 1'b1, 8'h02, 1'b1, 2'd3, 16'd2);

        bus.req_a[24 +: 8] = 8'd3;
        bus.req_b[24 +: 8] = 8'd5;
        #1;
        chk("borrow grant", 32'(bus.req_ready), 32'b1000);
        tick();
        chk_rsp("sub borrow", 1'b1, 8'hFE, 1'b0, 2'd3, 16'd3);

        bus.req_op = '0;
        for (int i = 0; i < 4; i++) begin
            bus.req_a[i*8 +: 8] = 8'(8'h10 * i + 1);
            bus.req_b[i*8 +: 8] = 8'(i);
        end
        bus.req_valid = 4'hF;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("rr grant %0d", k), 32'(bus.req_ready), 32'(1 << (k % 4)));
            tick();
            chk_rsp($sformatf("rr %0d", k), 1'b1, rr_sum[k % 4], 1'b0, 2'(k % 4), 16'(4 + k));
        end

        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b0010;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("bp ready %0d", k), 32'(bus.req_ready), 32'h0);
            tick();
            chk_rsp($sformatf("bp hold %0d", k), 1'b1, 8'h12, 1'b0, 2'd1, 16'd9);
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk("bp release grant", 32'(bus.req_ready), 32'b0010);
        tick();
        chk_rsp("bp refill", 1'b1, 8'h12, 1'b0, 2'd1, 16'd10);

        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'hF;
        rst_n         = 1'b0;
        #1;
        chk("midrst ready", 32'(bus.req_ready), 32'h0);
        tick();
        chk("midrst ready after", 32'(bus.req_ready), 32'h0);
        chk_rsp("midrst", 1'b0, 8'h00, 1'b0, 2'd0, 16'd0);
        rst_n         = 1'b1;
        bus.rsp_ready = 1'b1;
        #1;
        chk("post rst grant", 32'(bus.req_ready), 32'b0001);
        tick();
        chk_rsp("post rst", 1'b1, 8'h01, 1'b0, 2'd0, 16'd1);

        for (int k = 1; k < 65536; k++) tick();
        chk_rsp("wrap", 1'b1, 8'h34, 1'b0, 2'd3, 16'h0000);
        #1;
        chk("wrap grant", 32'(bus.req_ready), 32'b0001);
        tick();
        chk_rsp("after wrap", 1'b1, 8'h01, 1'b0, 2'd0, 16'h0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
